// File: rtl/qkt_pass1_rowmax.sv
// Pass-1 engine of the QKT softmax pipeline: streams the score matrix row by
// row, writes each row's signed maximum to the row-max buffer, then pulses done.
module qkt_pass1_rowmax #(
    parameter int DATA_W   = 16,
    parameter int ROW_LEN  = 64,
    parameter int NUM_ROWS = 64
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              enable_pass1,
    output logic              done_pass1,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              max_wr_en,
    output logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0] max_wr_addr,
    output logic [DATA_W-1:0] max_wr_data,
    output logic              busy
);

    localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;
    localparam logic [1:0] WAIT_LOW = 2'd3;

    // Pure compare-and-select, so extreme values cannot overflow.
    function automatic logic [DATA_W-1:0] signed_max(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        if ($signed(a) >= $signed(b)) begin
            signed_max = a;
        end else begin
            signed_max = b;
        end
    endfunction

    logic [1:0]        state_q,    state_d;
    logic [COL_W-1:0]  col_q,      col_d;
    logic [ROW_W-1:0]  row_q,      row_d;
    logic [DATA_W-1:0] run_max_q,  run_max_d;
    logic              done_q,     done_d;
    logic              wr_en_q,    wr_en_d;
    logic [ROW_W-1:0]  wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,  wr_data_d;
    logic              busy_q,     busy_d;
    logic              beat_s;
    logic [DATA_W-1:0] beat_max_s;

    assign s_ready     = (state_q == RUN);
    assign beat_s      = s_valid & s_ready;
    assign beat_max_s  = (col_q == {COL_W{1'b0}}) ? s_data : signed_max(run_max_q, s_data);
    assign done_pass1  = done_q;
    assign max_wr_en   = wr_en_q;
    assign max_wr_addr = wr_addr_q;
    assign max_wr_data = wr_data_q;
    assign busy        = busy_q;

    // Next-state logic; the row write is registered on the row's final beat so it
    // samples the completed maximum before the next row's column 0 overwrites it.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        run_max_d = run_max_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (enable_pass1) begin
                    col_d   = {COL_W{1'b0}};
                    row_d   = {ROW_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!enable_pass1) begin
                    state_d   = IDLE;
                    col_d     = {COL_W{1'b0}};
                    row_d     = {ROW_W{1'b0}};
                    run_max_d = {DATA_W{1'b0}};
                end else if (beat_s) begin
                    run_max_d = beat_max_s;
                    if (col_q == COL_LAST) begin
                        col_d     = {COL_W{1'b0}};
                        wr_en_d   = 1'b1;
                        wr_addr_d = row_q;
                        wr_data_d = beat_max_s;
                        if (row_q == ROW_LAST) begin
                            row_d   = {ROW_W{1'b0}};
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (enable_pass1) begin
                    state_d = WAIT_LOW;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!enable_pass1) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= IDLE;
            col_q     <= {COL_W{1'b0}};
            row_q     <= {ROW_W{1'b0}};
            run_max_q <= {DATA_W{1'b0}};
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ROW_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            run_max_q <= run_max_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_qkt_pass1_rowmax.sv
// Directed bench for qkt_pass1_rowmax with ROW_LEN=4, NUM_ROWS=2, DATA_W=16.
module tb_qkt_pass1_rowmax;

    typedef logic signed [15:0] row_t [4];

    logic               clk;
    logic               rst_;
    logic               enable_pass1;
    logic               done_pass1;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_data;
    logic               max_wr_en;
    logic [0:0]         max_wr_addr;
    logic signed [15:0] max_wr_data;
    logic               busy;

    int checks;
    int errors;

    qkt_pass1_rowmax #(.DATA_W(16), .ROW_LEN(4), .NUM_ROWS(2)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .enable_pass1 (enable_pass1),
        .done_pass1   (done_pass1),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .max_wr_en    (max_wr_en),
        .max_wr_addr  (max_wr_addr),
        .max_wr_data  (max_wr_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat's accepting edge.
    task automatic do_beat(input logic signed [15:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        chk("s_ready_run", int'(s_ready), 1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic run_row(input row_t v, input int row, input int expmax,
                           input int maxgap, input int last, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            do_beat(v[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            if (i < 3) begin
                chk("wr_en_midrow", int'(max_wr_en), 0);
            end else begin
                chk("wr_en_rowend", int'(max_wr_en), 1);
                chk("wr_addr", int'(max_wr_addr), row);
                chk("wr_data", int'(max_wr_data), expmax);
                chk("done_at_write", int'(done_pass1), last);
            end
        end
    endtask

    task automatic run_pass(input row_t a, input row_t b, input int ea, input int eb,
                            input int maxgap, input int hold);
        enable_pass1 = 1'b1;
        @(negedge clk);
        chk("busy_run", int'(busy), 1);
        run_row(a, 0, ea, maxgap, 0, 4);
        run_row(b, 1, eb, maxgap, 1, 4);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("wait_low_done", int'(done_pass1), 0);
            chk("wait_low_ready", int'(s_ready), 0);
            chk("wait_low_wr", int'(max_wr_en), 0);
        end
        enable_pass1 = 1'b0;
        @(negedge clk);
        chk("post_ready", int'(s_ready), 0);
        chk("post_done", int'(done_pass1), 0);
        chk("post_busy", int'(busy), 0);
        chk("post_wr", int'(max_wr_en), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, int'(done_pass1), 0);
        chk({tag, "_ready"}, int'(s_ready), 0);
        chk({tag, "_wr_en"}, int'(max_wr_en), 0);
        chk({tag, "_addr"}, int'(max_wr_addr), 0);
        chk({tag, "_data"}, int'(max_wr_data), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        row_t r0, r1, x0, x1;
        checks       = 0;
        errors       = 0;
        rst_         = 1'b0;
        enable_pass1 = 1'b0;
        s_valid      = 1'b0;
        s_data       = 16'sd0;
        r0 = '{16'sd3, -16'sd7, 16'sd12, 16'sd5};
        r1 = '{-16'sd2, -16'sd9, -16'sd1, -16'sd4};
        x0 = '{16'sh8000, 16'sh8000, 16'sh7FFF, -16'sd1};
        x1 = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_ = 1'b1;
        @(negedge clk);

        // Basic pass, enable dropped during the DONE cycle.
        run_pass(r0, r1, 12, -1, 0, 0);

        // Extreme values.
        run_pass(x0, x1, 32767, -32768, 0, 0);

        // s_valid high while idle must not be accepted, then a stalled pass.
        s_valid = 1'b1;
        s_data  = 16'sd100;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", int'(s_ready), 0);
            chk("idle_wr", int'(max_wr_en), 0);
        end
        s_valid = 1'b0;
        run_pass(r0, r1, 12, -1, 2, 0);

        // Enable held high after done, then a fresh pass from addr 0.
        run_pass(r0, r1, 12, -1, 0, 5);
        run_pass(x0, x1, 32767, -32768, 0, 0);

        // Abort after 6 beats.
        enable_pass1 = 1'b1;
        @(negedge clk);
        run_row(r0, 0, 12, 0, 0, 4);
        run_row(r1, 1, -1, 0, 0, 2);
        enable_pass1 = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(s_ready), 0);
        repeat (3) begin
            chk("abort_wr", int'(max_wr_en), 0);
            chk("abort_done", int'(done_pass1), 0);
            @(negedge clk);
        end
        run_pass(r0, r1, 12, -1, 0, 0);

        // Reset asserted mid-row.
        enable_pass1 = 1'b1;
        @(negedge clk);
        run_row(r0, 0, 12, 0, 0, 4);
        run_row(r1, 1, -1, 0, 0, 2);
        chk("pre_reset_data", int'(max_wr_data), 12);
        #2;
        rst_ = 1'b0;
        #1;
        chk_all_zero("async_reset");
        enable_pass1 = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        run_pass(x0, r1, 32767, -1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
